// File: rtl/ysyx_22040895_mdu.sv
// Iterative radix-2 RV64M multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Signed operands are reduced to magnitudes on accept; the sign is reapplied in a single FIX cycle.
module ysyx_22040895_mdu #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i_mdu,
   output logic            ready_o_mdu,
   input  logic [2:0]      op_i_mdu,
   input  logic            word_i_mdu,
   input  logic [XLEN-1:0] opnum1_i_mdu,
   input  logic [XLEN-1:0] opnum2_i_mdu,
   input  logic            flush_i_mdu,
   output logic            valid_o_mdu,
   input  logic            ready_i_mdu,
   output logic [XLEN-1:0] result_o_mdu,
   output logic            busy_o_mdu
);
   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     counter_reg;
   logic [2:0]        op_reg;
   logic              word_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [XLEN-1:0]   opb_reg;
   logic              neg_q_reg;
   logic              neg_r_reg;
   logic [XLEN-1:0]   result_reg;

   // Request decode and operand conditioning
   logic [2:0]      eff_op;
   logic            is_div, rem_op, s1_en, s2_en;
   logic            a_neg, b_neg, div_zero, div_ovf, fast_path, accept;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, fast_raw, fast_result;

   always_comb begin
      // Word forms of MULH/MULHSU/MULHU are not legal; they fall back to MULW.
      eff_op = (word_i_mdu && !op_i_mdu[2] && (op_i_mdu != 3'd0)) ? 3'd0 : op_i_mdu;
      is_div = eff_op[2];
      rem_op = eff_op[1];
      s1_en  = (eff_op != 3'd3) && (eff_op != 3'd5) && (eff_op != 3'd7);
      s2_en  = s1_en && (eff_op != 3'd2);
      if (word_i_mdu) begin
         a_ext = {{HALF{s1_en & opnum1_i_mdu[HALF-1]}}, opnum1_i_mdu[HALF-1:0]};
         b_ext = {{HALF{s2_en & opnum2_i_mdu[HALF-1]}}, opnum2_i_mdu[HALF-1:0]};
      end else begin
         a_ext = opnum1_i_mdu;
         b_ext = opnum2_i_mdu;
      end
      a_neg     = s1_en & a_ext[XLEN-1];
      b_neg     = s2_en & b_ext[XLEN-1];
      a_abs     = a_neg ? -a_ext : a_ext;
      b_abs     = b_neg ? -b_ext : b_ext;
      min_val   = word_i_mdu ? ({XLEN{1'b1}} << (HALF - 1)) : ({XLEN{1'b1}} << (XLEN - 1));
      div_zero  = is_div && (b_ext == '0);
      div_ovf   = is_div && s1_en && (a_ext == min_val) && (b_ext == '1);
      fast_path = div_zero | div_ovf;
      if (div_zero) fast_raw = rem_op ? a_ext : '1;
      else          fast_raw = rem_op ? '0 : a_ext;
      fast_result = word_i_mdu ? {{HALF{fast_raw[HALF-1]}}, fast_raw[HALF-1:0]} : fast_raw;
      accept      = valid_i_mdu && (state_reg == IDLE) && !flush_i_mdu;
   end

   // One iteration step; the accumulator is {hi, lo}
   logic [XLEN-1:0]   acc_hi, acc_lo;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_step, div_step;

   always_comb begin
      acc_hi    = acc_reg[2*XLEN-1:XLEN];
      acc_lo    = acc_reg[XLEN-1:0];
      mul_sum   = acc_reg[0] ? ({1'b0, acc_hi} + {1'b0, opb_reg}) : {1'b0, acc_hi};
      mul_step  = {mul_sum, acc_lo[XLEN-1:1]};
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_ge    = div_shift >= {1'b0, opb_reg};
      div_diff  = div_shift - {1'b0, opb_reg};
      div_step  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_lo[XLEN-2:0], div_ge};
   end

   // Sign fix-up and result selection
   logic [2*XLEN-1:0] prod_raw, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_raw, fix_result;

   always_comb begin
      // A word multiply runs HALF steps, leaving the product HALF bits up.
      prod_raw = word_reg ? (acc_reg >> HALF) : acc_reg;
      prod_fix = neg_q_reg ? -prod_raw : prod_raw;
      quot_fix = neg_q_reg ? -acc_lo : acc_lo;
      rem_fix  = neg_r_reg ? -acc_hi : acc_hi;
      case (op_reg)
         3'd0:                fix_raw = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    fix_raw = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:          fix_raw = quot_fix;
         default:             fix_raw = rem_fix;
      endcase
      fix_result = word_reg ? {{HALF{fix_raw[HALF-1]}}, fix_raw[HALF-1:0]} : fix_raw;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = fast_path ? DONE : CALC;
         CALC:    if (counter_reg == CW'(1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    if (ready_i_mdu) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i_mdu) state_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter_reg <= '0;
         op_reg      <= '0;
         word_reg    <= 1'b0;
         acc_reg     <= '0;
         opb_reg     <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         result_reg  <= '0;
      end else if (!flush_i_mdu) begin
         case (state_reg)
            IDLE: if (accept) begin
               op_reg      <= eff_op;
               word_reg    <= word_i_mdu;
               counter_reg <= word_i_mdu ? CW'(HALF) : CW'(XLEN);
               neg_q_reg   <= a_neg ^ b_neg;
               neg_r_reg   <= a_neg;
               if (is_div) begin
                  acc_reg <= {{XLEN{1'b0}}, (word_i_mdu ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs)};
                  opb_reg <= b_abs;
               end else begin
                  acc_reg <= {{XLEN{1'b0}}, (word_i_mdu ? {{HALF{1'b0}}, b_abs[HALF-1:0]} : b_abs)};
                  opb_reg <= a_abs;
               end
               if (fast_path) result_reg <= fast_result;
            end
            CALC: begin
               acc_reg     <= op_reg[2] ? div_step : mul_step;
               counter_reg <= counter_reg - CW'(1);
            end
            FIX:     result_reg <= fix_result;
            default: ;
         endcase
      end
   end

   assign ready_o_mdu  = (state_reg == IDLE);
   assign valid_o_mdu  = (state_reg == DONE);
   assign busy_o_mdu   = (state_reg != IDLE);
   assign result_o_mdu = result_reg;
endmodule
